// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per BUSY cycle, valid/ready on both sides.
// State bytes are packed as [column][row]: column c, row r lives at bits [32*c + 8*r +: 8].
module inv_mix_columns_seq #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] block_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] block_out,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $fatal(1, "inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] in_reg_q, in_reg_d;
  logic [127:0] out_reg_q, out_reg_d;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiples 9, b, d, e built from the x2/x4/x8 xtime chain of each row byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    for (int r = 0; r < 4; r++) begin
      a     = col[8*r +: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a;
      mb[r] = x8 ^ x2 ^ a;
      md[r] = x8 ^ x4 ^ a;
      me[r] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[8*r +: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    in_reg_d  = in_reg_q;
    out_reg_d = out_reg_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      StIdle: begin
        // Held low while reset is asserted so nothing is offered during reset.
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          in_reg_d  = block_in;
          col_cnt_d = 2'd0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        busy = 1'b1;
        for (int i = 0; i < int'(COLS_PER_CYCLE); i++) begin
          out_reg_d[{col_cnt_q + 2'(i), 5'b0} +: 32] =
            inv_mix_col(in_reg_q[{col_cnt_q + 2'(i), 5'b0} +: 32]);
        end
        if ((3'(col_cnt_q) + 3'(COLS_PER_CYCLE)) == 3'd4) begin
          col_cnt_d = 2'd0;
          state_d   = StDone;
        end else begin
          col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            in_reg_d  = block_in;
            col_cnt_d = 2'd0;
            state_d   = StBusy;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      col_cnt_q <= 2'd0;
      in_reg_q  <= '0;
      out_reg_q <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      in_reg_q  <= in_reg_d;
      out_reg_q <= out_reg_d;
    end
  end

  assign block_out = out_reg_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: main N=1 instance plus N=2 and N=4 latency instances.
module tb_inv_mix_columns_seq;

  localparam int TIMEOUT = 200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] block_in = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] block_out;

  logic [1:0]   in_valid_x = 2'b00;
  logic [1:0]   in_ready_x, out_valid_x, busy_x;
  logic [127:0] block_out_x [2];

  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           rand_ready = 1'b0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .block_in(block_in),
    .out_valid(out_valid), .out_ready(out_ready), .block_out(block_out), .busy(busy)
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x[0]), .in_ready(in_ready_x[0]),
    .block_in(block_in), .out_valid(out_valid_x[0]), .out_ready(1'b1),
    .block_out(block_out_x[0]), .busy(busy_x[0])
  );

  inv_mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_x[1]), .in_ready(in_ready_x[1]),
    .block_in(block_in), .out_valid(out_valid_x[1]), .out_ready(1'b1),
    .block_out(block_out_x[1]), .busy(busy_x[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mkcol(input logic [31:0] r);
    return {r[7:0], r[15:8], r[23:16], r[31:24]};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product; inverse selects InvMixColumns, otherwise MixColumns.
  function automatic logic [127:0] mix_model(input logic [127:0] blk, input bit inverse);
    logic [7:0]   co [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inverse) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         co = '{8'h02, 8'h03, 8'h01, 8'h01};
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(co[(k - r + 4) % 4], blk[c*32 + k*8 +: 8]);
        res[c*32 + r*8 +: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
      if (exp_q.size() != 0) check("sb_data", block_out, exp_q.pop_front());
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [127:0] blk, input logic [127:0] exp, output int acc);
    bit got;
    got      = 1'b0;
    acc      = -1;
    block_in = blk;
    in_valid = 1'b1;
    for (int t = 0; t < TIMEOUT && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        acc = cyc;
        exp_q.push_back(exp);
      end
    end
    check("send_accepted", 128'(got), 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] b1, e1, b2, e2, held, b, c6;
    int lat, a1, a2, a3, l2, l4;

    b1 = {96'h0, mkcol(32'h8e4da1bc)};
    e1 = {96'h0, mkcol(32'hdb135345)};
    b2 = {mkcol(32'h4d7ebdf8), mkcol(32'h01010101), mkcol(32'hd5d5d7d6), mkcol(32'h9fdc589d)};
    e2 = {mkcol(32'h2d26314c), mkcol(32'h01010101), mkcol(32'hd4d4d4d5), mkcol(32'hf20a225c)};
    c6 = {4{32'hc6c6c6c6}};

    // Reset state
    #12;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_block_out", block_out, 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);

    // T1 single column, latency 4
    out_ready = 1'b1;
    send(b1, e1, a1);
    in_valid = 1'b0;
    check("t1_busy", 128'(busy), 128'd1);
    wait_valid(lat);
    check("t1_latency", 128'(lat), 128'd4);
    check("t1_data", block_out, e1);
    idle(2);

    // T2 FIPS-197 columns on N=1, then N=2 and N=4 side by side
    send(b2, e2, a1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("t2_n1_latency", 128'(lat), 128'd4);
    check("t2_n1_data", block_out, e2);
    idle(2);
    block_in   = b2;
    in_valid_x = 2'b11;
    @(posedge clk);
    #1;
    in_valid_x = 2'b00;
    l2 = 0;
    l4 = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1 || 1) ;
      @(posedge clk);
      #1;
      if (out_valid_x[0] && l2 == 0) begin
        l2 = c;
        check("t2_n2_data", block_out_x[0], e2);
      end
      if (out_valid_x[1] && l4 == 0) begin
        l4 = c;
        check("t2_n4_data", block_out_x[1], e2);
      end
    end
    check("t2_n2_latency", 128'(l2), 128'd2);
    check("t2_n4_latency", 128'(l4), 128'd1);

    // T3 backpressure for 10 cycles
    out_ready = 1'b0;
    send(b1, e1, a1);
    in_valid = 1'b0;
    wait_valid(lat);
    held = block_out;
    check("t3_held_data", held, e1);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("t3_stable", block_out, held);
      check("t3_out_valid", 128'(out_valid), 128'd1);
      check("t3_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_after_out_valid", 128'(out_valid), 128'd0);
    check("t3_after_in_ready", 128'(in_ready), 128'd1);
    check("t3_after_busy", 128'(busy), 128'd0);

    // T4 back-to-back, period 5
    b = rand_block();
    send(b, mix_model(b, 1'b1), a1);
    b = rand_block();
    send(b, mix_model(b, 1'b1), a2);
    send(b2, e2, a3);
    in_valid = 1'b0;
    check("t4_period_12", 128'(a2 - a1), 128'd5);
    check("t4_period_23", 128'(a3 - a2), 128'd5);
    idle(8);
    check("t4_drained", 128'(exp_q.size()), 128'd0);

    // T5 reset with col_cnt = 2
    send(b2, e2, a1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t5_busy_before", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    check("t5_out_valid", 128'(out_valid), 128'd0);
    check("t5_busy", 128'(busy), 128'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(c6, c6, a1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("t5_latency", 128'(lat), 128'd4);
    check("t5_data", block_out, c6);
    idle(2);

    // T6 random states with gaps and random backpressure, then MixColumns round trips
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      b = rand_block();
      send(b, mix_model(b, 1'b1), a1);
      idle($urandom_range(0, 3));
    end
    for (int i = 0; i < 200; i++) begin
      b = rand_block();
      send(mix_model(b, 1'b0), b, a1);
      idle($urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    check("t6_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
